// File: rtl/write_back_unit_pkg.sv
// Shared types for the write-back unit: kind codes,
// load width codes, FSM states and the capture bundle.
package write_back_unit_pkg;

  typedef enum logic [1:0] {
    KIND_ALU  = 2'b00,
    KIND_LOAD = 2'b01,
    KIND_LINK = 2'b10,
    KIND_NONE = 2'b11
  } wb_kind_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_WAIT_MEM = 2'b01,
    S_WRITE    = 2'b10
  } wb_state_e;

  typedef struct packed {
    logic [4:0]  rd;
    wb_kind_e    kind;
    logic [31:0] result;
    logic [31:0] pc4;
    logic [2:0]  funct3;
  } wb_cap_t;

endpackage

// File: rtl/write_back_unit_load_align.sv
// Load data extraction: byte/half select by address,
// sign or zero extension by width code.
module load_align
  import write_back_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        is_b;
  logic        is_h;
  logic        sx;

  always_comb begin
    b    = word[{addr, 3'b000} +: 8];
    h    = addr[1] ? word[31:16] : word[15:0];
    is_b = (funct3 == F3_LB) || (funct3 == F3_LBU);
    is_h = (funct3 == F3_LH) || (funct3 == F3_LHU);
    sx   = (funct3 == F3_LB) || (funct3 == F3_LH);
    data = word;
    // anything not a byte/half code, LW included, passes the word
    unique case (1'b1)
      is_b:    data = {{24{sx & b[7]}}, b};
      is_h:    data = {{16{sx & h[15]}}, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/write_back_unit.sv
// Write-back stage: accepts ALU/LOAD/LINK results and drives
// the register-file write port, waiting on memory for loads.
module write_back_unit
  import write_back_unit_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [1:0]  wb_kind,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_result,
  input  logic [31:0] wb_pc4,
  input  logic [2:0]  wb_funct3,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        RegWrite,
  output logic [4:0]  write_address,
  output logic [31:0] write_dataR,
  output logic [31:0] write_dataPC4,
  output logic        write_PC4,
  output logic        busy,
  output logic [4:0]  busy_rd,
  output logic        load_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  wb_state_e   state_q;
  wb_state_e   state_d;
  wb_cap_t     cap_q;
  logic [TW-1:0] timer_q;

  logic        accept;
  logic        wr_go;
  logic        tmr_clr;
  logic        tmr_inc;
  logic [4:0]  nx_rd;
  logic [31:0] nx_data;
  logic [31:0] nx_pc4;
  logic        nx_link;
  logic [31:0] ld_data;

  load_align u_align (
    .funct3 (cap_q.funct3),
    .addr   (cap_q.result[1:0]),
    .word   (mem_rdata),
    .data   (ld_data)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    wr_go    = 1'b0;
    tmr_clr  = 1'b0;
    tmr_inc  = 1'b0;
    load_err = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (wb_valid) begin
          accept = 1'b1;
          if (wb_kind == KIND_LOAD) begin
            state_d = S_WAIT_MEM;
            tmr_clr = 1'b1;
          end else if (wb_kind != KIND_NONE) begin
            state_d = S_WRITE;
            wr_go   = 1'b1;
          end
        end
      end
      S_WAIT_MEM: begin
        if (mem_rvalid) begin
          state_d = S_WRITE;
          wr_go   = 1'b1;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d  = S_IDLE;
          load_err = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // write-port values come straight from the request when
  // entering WRITE from IDLE, otherwise from the capture
  always_comb begin
    if (state_q == S_IDLE) begin
      nx_rd   = wb_rd;
      nx_data = wb_result;
      nx_pc4  = wb_pc4;
      nx_link = (wb_kind == KIND_LINK);
    end else begin
      nx_rd   = cap_q.rd;
      nx_data = (cap_q.kind == KIND_LOAD) ? ld_data
                                          : cap_q.result;
      nx_pc4  = cap_q.pc4;
      nx_link = (cap_q.kind == KIND_LINK);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cap_q         <= '0;
      timer_q       <= '0;
      RegWrite      <= 1'b0;
      write_PC4     <= 1'b0;
      write_address <= '0;
      write_dataR   <= '0;
      write_dataPC4 <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cap_q.rd     <= wb_rd;
        cap_q.kind   <= wb_kind_e'(wb_kind);
        cap_q.result <= wb_result;
        cap_q.pc4    <= wb_pc4;
        cap_q.funct3 <= wb_funct3;
      end
      if (tmr_clr) begin
        timer_q <= '0;
      end else if (tmr_inc) begin
        timer_q <= timer_q + 1'b1;
      end
      RegWrite  <= wr_go && (nx_rd != 5'd0);
      write_PC4 <= wr_go && nx_link;
      if (wr_go) begin
        write_address <= nx_rd;
        write_dataR   <= nx_data;
        write_dataPC4 <= nx_pc4;
      end
    end
  end

  assign wb_ready = reset && (state_q == S_IDLE);
  assign busy     = ((state_q == S_WAIT_MEM) ||
                     (state_q == S_WRITE)) &&
                    (cap_q.rd != 5'd0);
  assign busy_rd  = cap_q.rd;

endmodule

// File: doc/write_back_unit.md
WRITE_BACK_UNIT -- requirements
Module: write_back_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum cycles spent waiting for load data before the load is aborted.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port wb_valid, input, 1: a writeback request is presented.
REQ-005 SHALL have port wb_ready, output, 1: the unit accepts a request this cycle.
REQ-006 SHALL have port wb_kind, input, 2: 00 ALU, 01 LOAD, 10 LINK (PC+4), 11 NONE (no register write).
REQ-007 SHALL have port wb_rd, input, 5: destination register index.
REQ-008 SHALL have port wb_result, input, 32: ALU result; for LOAD, the byte address (only bits [1:0] used).
REQ-009 SHALL have port wb_pc4, input, 32: PC+4 for LINK.
REQ-010 SHALL have port wb_funct3, input, 3: load width code (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
REQ-011 SHALL have port mem_rvalid, input, 1: load data valid; one-cycle pulse.
REQ-012 SHALL have port mem_rdata, input, 32: aligned load word.
REQ-013 SHALL have ports RegWrite (output, 1), write_address (output, 5), write_dataR (output, 32), write_dataPC4 (output, 32) and write_PC4 (output, 1): the register-file write port.
REQ-014 SHALL have ports busy (output, 1) and busy_rd (output, 5): a write to busy_rd is pending, for hazard stall.
REQ-015 SHALL have port load_err, output, 1: one-cycle pulse when a load times out.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT_MEM and WRITE.
REQ-017 IDLE SHALL drive wb_ready=1; when wb_valid is high, it SHALL capture rd, kind, result, pc4, funct3 and addr[1:0].
REQ-018 IDLE, on accepting ALU or LINK, SHALL go to WRITE; on LOAD, to WAIT_MEM with the timer cleared; on NONE, SHALL stay in IDLE and write nothing.
REQ-019 WAIT_MEM SHALL drive wb_ready=0 and SHALL increment the timer each cycle while mem_rvalid is low.
REQ-020 WAIT_MEM, when mem_rvalid is high, SHALL register the extracted load data and go to WRITE; mem_rvalid arriving in the same cycle the LOAD is accepted SHALL be ignored.
REQ-021 Load extraction: LB/LBU SHALL select byte addr[1:0]; LH/LHU SHALL select half addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through; undefined funct3 SHALL behave as LW.
REQ-022 WAIT_MEM, when the timer reaches TIMEOUT-1 with no data, SHALL pulse load_err, perform no write, and return to IDLE.
REQ-023 WRITE SHALL assert RegWrite for exactly one cycle, with write_address equal to the captured rd, and SHALL go to IDLE.
REQ-024 WRITE SHALL keep wb_ready=0, so a new request is accepted no earlier than the cycle after WRITE.
REQ-025 In WRITE, write_PC4 SHALL be 1 for LINK and 0 otherwise; write_dataPC4 SHALL be the captured pc4; write_dataR SHALL be the ALU result or the extracted load data.
REQ-026 A captured rd of 0 SHALL suppress RegWrite while the FSM still passes through WRITE.
REQ-027 Latency: ALU/LINK SHALL write 1 cycle after acceptance; LOAD SHALL write 1 cycle after mem_rvalid.
REQ-028 busy SHALL be 1 in WAIT_MEM and in WRITE when the captured rd is nonzero; busy_rd SHALL equal the captured rd.
REQ-029 Outside WRITE, RegWrite and write_PC4 SHALL be 0, and the data outputs SHALL hold their last values.

Reset
REQ-030 Reset low SHALL immediately force IDLE and clear the timer, all captured fields and all outputs to 0 (wb_ready=0 during reset, 1 after); a pending load SHALL be discarded without load_err.
REQ-031 mem_rvalid arriving after reset SHALL be ignored in IDLE.

Structure
REQ-032 A shared package SHALL hold the wb_kind encodings, the funct3 load codes and the FSM state typedef.
REQ-033 Load extraction SHALL be the sub-module load_align (combinational: funct3, addr[1:0] and word in; 32-bit data out).

Verification
REQ-034 ALU, rd=5, result 0x0000_1234 -> next cycle RegWrite=1, write_address=5, write_dataR=0x1234, write_PC4=0.
REQ-035 LINK, rd=1, pc4 0x0000_0104 -> next cycle RegWrite=1, write_PC4=1, write_dataPC4=0x104.
REQ-036 LB, addr 0x3, mem_rdata 0x80FF_FF7F -> write_dataR 0xFFFF_FF80; the same with LBU -> 0x0000_0080; LH, addr 0x2 -> 0xFFFF_80FF.
REQ-037 LOAD with no mem_rvalid for 16 cycles -> load_err pulse, no RegWrite, wb_ready=1 the next cycle.
REQ-038 ALU with rd=0 -> RegWrite stays 0 and busy stays 0; reset asserted mid-WAIT_MEM -> IDLE, no write, a late mem_rvalid is ignored.
